// File: rtl/ble_tx_whitening_if.sv
// Bit-stream and control bundle between the CRC stage, the whitening stage and the modulator.
// master drives frame control and bits; slave is the whitening stage.
interface ble_tx_whitening_if #(
  parameter int LEN_W = 14
);
  logic             start;
  logic [5:0]       channel_index;
  logic [LEN_W-1:0] num_bits;
  logic             valid_in;
  logic             data_in;
  logic             valid_out;
  logic             data_out;
  logic             busy;
  logic             finished;
  logic             overrun;
  logic [LEN_W-1:0] bit_count;

  modport master (
    output start, channel_index, num_bits, valid_in, data_in,
    input  valid_out, data_out, busy, finished, overrun, bit_count
  );

  modport slave (
    input  start, channel_index, num_bits, valid_in, data_in,
    output valid_out, data_out, busy, finished, overrun, bit_count
  );
endinterface

// File: rtl/ble_tx_whitening.sv
// BLE data whitening: serial bits XORed with a channel-seeded x^7+x^4+1 LFSR,
// one registered output stage, with frame-end pulse and sticky overrun flag.
module ble_tx_whitening #(
  parameter int LEN_W = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  ble_tx_whitening_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, WHITEN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [6:0]       lfsr_reg, lfsr_next;
  logic [6:0]       lfsr_seed, lfsr_shift;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] count_reg, count_next, count_inc;
  logic             overrun_reg, overrun_next;
  logic             valid_out_reg, valid_out_next;
  logic             data_out_reg, data_out_next;
  logic             finished_reg, finished_next;

  // lfsr bit i holds position p_i; channel MSB lands in p1, LSB in p6
  assign lfsr_seed[0]  = 1'b1;
  assign lfsr_shift[0] = lfsr_reg[6];

  genvar gi;
  generate
    for (gi = 1; gi < 7; gi++) begin : g_lfsr
      assign lfsr_seed[gi] = bus.channel_index[6-gi];
      if (gi == 4) begin : g_tap
        assign lfsr_shift[gi] = lfsr_reg[gi-1] ^ lfsr_reg[6];
      end else begin : g_plain
        assign lfsr_shift[gi] = lfsr_reg[gi-1];
      end
    end
  endgenerate

  assign count_inc = count_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    lfsr_next      = lfsr_reg;
    len_next       = len_reg;
    count_next     = count_reg;
    overrun_next   = overrun_reg;
    valid_out_next = 1'b0;
    data_out_next  = 1'b0;
    finished_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // start wins over a coincident valid_in, so overrun stays clear
        if (bus.start) begin
          lfsr_next    = lfsr_seed;
          len_next     = bus.num_bits;
          count_next   = '0;
          overrun_next = 1'b0;
          state_next   = (bus.num_bits == '0) ? DONE : WHITEN;
        end else if (bus.valid_in) begin
          overrun_next = 1'b1;
        end
      end
      WHITEN: begin
        if (bus.valid_in) begin
          valid_out_next = 1'b1;
          data_out_next  = bus.data_in ^ lfsr_reg[6];
          lfsr_next      = lfsr_shift;
          count_next     = count_inc;
          if (count_inc == len_reg) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        finished_next = 1'b1;
        state_next    = IDLE;
        if (bus.valid_in) begin
          overrun_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      lfsr_reg      <= 7'b0000001;
      len_reg       <= '0;
      count_reg     <= '0;
      overrun_reg   <= 1'b0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= 1'b0;
      finished_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      len_reg       <= len_next;
      count_reg     <= count_next;
      overrun_reg   <= overrun_next;
      valid_out_reg <= valid_out_next;
      data_out_reg  <= data_out_next;
      finished_reg  <= finished_next;
    end
  end

  assign bus.valid_out = valid_out_reg;
  assign bus.data_out  = data_out_reg;
  assign bus.busy      = (state_reg == WHITEN);
  assign bus.finished  = finished_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.bit_count = count_reg;

endmodule

// File: tb/tb_ble_tx_whitening.sv
// Randomized bench for ble_tx_whitening against a per-bit whitening reference model.
module tb_ble_tx_whitening;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ble_tx_whitening_if #(.LEN_W(14)) bus ();

  ble_tx_whitening #(.LEN_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fin_count = 0;
  int fin_cyc = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  int busy_drops = 0;
  bit tx_bits [64];
  bit orig_bits [64];
  bit rx_q [$];
  bit exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      rx_q.push_back(bus.data_out);
      last_valid_cyc = cyc;
    end
    if (bus.finished === 1'b1) begin
      fin_count++;
      fin_cyc = cyc;
    end
  end

  // Reference: positions p0..p6 as an array, output p6, rotate up, XOR feedback into p4
  function automatic void model(input int ch, input int len);
    int s [7];
    int fb;
    exp_q.delete();
    s[0] = 1;
    for (int k = 1; k < 7; k++) s[k] = (ch >> (6 - k)) & 1;
    for (int i = 0; i < len; i++) begin
      fb = s[6];
      exp_q.push_back(tx_bits[i] ^ bit'(fb));
      for (int k = 6; k > 0; k--) s[k] = s[k-1];
      s[0] = fb;
      s[4] = s[4] ^ fb;
    end
  endfunction

  task automatic send_frame(input int ch, input int len, input int gap,
                            input int restart_at, input bit vin_with_start);
    bit got_fin;
    rx_q.delete();
    fin_count  = 0;
    busy_drops = 0;
    @(negedge clk);
    bus.start         = 1'b1;
    bus.channel_index = 6'(ch);
    bus.num_bits      = 14'(len);
    bus.valid_in      = vin_with_start;
    bus.data_in       = 1'b1;
    start_cyc         = cyc;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (bus.busy !== 1'b1) busy_drops++;
      bus.valid_in = 1'b1;
      bus.data_in  = tx_bits[i];
      if (i == restart_at) begin
        bus.start         = 1'b1;
        bus.channel_index = 6'd7;
        bus.num_bits      = 14'd3;
      end
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.start    = 1'b0;
      bus.data_in  = 1'b0;
      if (i < len - 1) begin
        repeat (gap) begin
          if (bus.busy !== 1'b1) busy_drops++;
          @(negedge clk);
        end
      end
    end
    got_fin = 1'b0;
    for (int t = 0; t < 20 && !got_fin; t++) begin
      if (bus.finished === 1'b1) got_fin = 1'b1;
      else @(negedge clk);
    end
    #1;
    checks++;
    if (!got_fin) begin
      errors++;
      $display("FAIL finished_timeout: finished=%0b after 20 cycles, required 1", bus.finished);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out: got %0b want 0", bus.valid_out); end
    if (bus.data_out  !== 1'b0) begin errors++; $display("FAIL rst_data_out: got %0b want 0", bus.data_out); end
    if (bus.busy      !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    if (bus.finished  !== 1'b0) begin errors++; $display("FAIL rst_finished: got %0b want 0", bus.finished); end
    if (bus.overrun   !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %0b want 0", bus.overrun); end
    if (bus.bit_count !== 14'd0) begin errors++; $display("FAIL rst_bit_count: got %0d want 0", bus.bit_count); end
    // mid-frame asynchronous reset
    fin_count = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.channel_index = 6'd5; bus.num_bits = 14'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      bus.valid_in = 1'b1; bus.data_in = 1'b1;
      @(negedge clk);
    end
    bus.valid_in = 1'b0; bus.data_in = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (bus.busy      !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %0b want 0", bus.busy); end
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL async_rst_valid_out: got %0b want 0", bus.valid_out); end
    if (bus.data_out  !== 1'b0) begin errors++; $display("FAIL async_rst_data_out: got %0b want 0", bus.data_out); end
    if (bus.bit_count !== 14'd0) begin errors++; $display("FAIL async_rst_bit_count: got %0d want 0", bus.bit_count); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (fin_count !== 0) begin errors++; $display("FAIL rst_no_finished: got %0d pulses want 0", fin_count); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %0b want 0", bus.busy); end
    $display("test_reset done");
  endtask

  task automatic test_ch37(input int gap, input string name);
    bit ref_seq [5];
    ref_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) tx_bits[i] = 1'b0;
    send_frame(37, 5, gap, -1, 1'b0);
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL %s_count: got %0d bits want 5", name, rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== ref_seq[i]) begin
          errors++; $display("FAIL %s_bit%0d: got %0b want %0b", name, i, rx_q[i], ref_seq[i]);
        end
      end
    end
    checks += 3;
    if (fin_cyc != last_valid_cyc + 1) begin
      errors++; $display("FAIL %s_fin_timing: finished cycle %0d want %0d", name, fin_cyc, last_valid_cyc + 1);
    end
    if (bus.bit_count !== 14'd5) begin
      errors++; $display("FAIL %s_bit_count: got %0d want 5", name, bus.bit_count);
    end
    if (busy_drops != 0) begin
      errors++; $display("FAIL %s_busy: busy low on %0d cycles, want 0", name, busy_drops);
    end
    $display("%s done: ch=37 gap=%0d bits=%0d", name, gap, rx_q.size());
  endtask

  task automatic test_involution();
    for (int i = 0; i < 40; i++) begin
      tx_bits[i]   = 1'($urandom);
      orig_bits[i] = tx_bits[i];
    end
    model(12, 40);
    send_frame(12, 40, 0, -1, 1'b0);
    checks++;
    if (rx_q.size() != 40) begin
      errors++; $display("FAIL invol_pass1_count: got %0d want 40", rx_q.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL invol_pass1_bit%0d: got %0b want %0b", i, rx_q[i], exp_q[i]);
        end
        tx_bits[i] = rx_q[i];
      end
    end
    send_frame(12, 40, 0, -1, 1'b0);
    checks++;
    if (rx_q.size() != 40) begin
      errors++; $display("FAIL invol_pass2_count: got %0d want 40", rx_q.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (rx_q[i] !== orig_bits[i]) begin
          errors++; $display("FAIL invol_pass2_bit%0d: got %0b want %0b", i, rx_q[i], orig_bits[i]);
        end
      end
    end
    $display("test_involution done: ch=12 len=40");
  endtask

  task automatic test_zero_len();
    send_frame(5, 0, 0, -1, 1'b0);
    checks += 3;
    if (rx_q.size() != 0) begin errors++; $display("FAIL zero_len_valid: got %0d bits want 0", rx_q.size()); end
    if (fin_count != 1) begin errors++; $display("FAIL zero_len_pulses: got %0d want 1", fin_count); end
    if (fin_cyc != start_cyc + 2) begin
      errors++; $display("FAIL zero_len_fin_timing: finished cycle %0d want %0d", fin_cyc, start_cyc + 2);
    end
    $display("test_zero_len done");
  endtask

  task automatic test_overrun();
    @(negedge clk);
    bus.valid_in = 1'b1; bus.data_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0; bus.data_in = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b want 1", bus.overrun); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %0b want 1", bus.overrun); end
    for (int i = 0; i < 8; i++) tx_bits[i] = 1'($urandom);
    model(20, 8);
    send_frame(20, 8, 0, 3, 1'b0);
    checks += 3;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %0b want 0", bus.overrun); end
    if (bus.bit_count !== 14'd8) begin errors++; $display("FAIL restart_bit_count: got %0d want 8", bus.bit_count); end
    if (rx_q.size() != 8) begin
      errors++; $display("FAIL restart_len: got %0d bits want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL restart_bit%0d: got %0b want %0b", i, rx_q[i], exp_q[i]);
        end
      end
    end
    // start with coincident valid_in: bit dropped, overrun stays clear
    for (int i = 0; i < 4; i++) tx_bits[i] = 1'($urandom);
    model(9, 4);
    send_frame(9, 4, 1, -1, 1'b1);
    checks += 2;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL start_vin_overrun: got %0b want 0", bus.overrun); end
    if (rx_q.size() != 4) begin
      errors++; $display("FAIL start_vin_len: got %0d bits want 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL start_vin_bit%0d: got %0b want %0b", i, rx_q[i], exp_q[i]);
        end
      end
    end
    $display("test_overrun done");
  endtask

  task automatic test_back_to_back();
    int ch, len, gap, bad;
    for (int f = 0; f < 6; f++) begin
      ch  = int'($urandom_range(39, 0));
      len = int'($urandom_range(24, 1));
      gap = int'($urandom_range(2, 0));
      for (int i = 0; i < len; i++) tx_bits[i] = 1'($urandom);
      model(ch, len);
      send_frame(ch, len, gap, -1, 1'b0);
      bad = 0;
      checks += 3;
      if (rx_q.size() != len) begin
        errors++; bad++; $display("FAIL b2b%0d_len: got %0d bits want %0d", f, rx_q.size(), len);
      end else begin
        for (int i = 0; i < len; i++) begin
          checks++;
          if (rx_q[i] !== exp_q[i]) begin
            errors++; bad++; $display("FAIL b2b%0d_bit%0d: got %0b want %0b", f, i, rx_q[i], exp_q[i]);
          end
        end
      end
      if (bus.bit_count !== 14'(len)) begin
        errors++; bad++; $display("FAIL b2b%0d_bit_count: got %0d want %0d", f, bus.bit_count, len);
      end
      if (fin_cyc != last_valid_cyc + 1) begin
        errors++; bad++; $display("FAIL b2b%0d_fin_timing: finished cycle %0d want %0d", f, fin_cyc, last_valid_cyc + 1);
      end
      $display("b2b frame %0d: ch=%0d len=%0d gap=%0d errors=%0d", f, ch, len, gap, bad);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.channel_index = 6'd0; bus.num_bits = 14'd0;
    bus.valid_in = 1'b0; bus.data_in = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_ch37(0, "ch37_zero");
    test_involution();
    test_ch37(3, "ch37_gapped");
    test_zero_len();
    test_overrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
